// File: rtl/axi_read_arbiter_if.sv
// AXI4 read-only bundle (AR + R channels) for N_PORTS agents packed side by
// side: agent p owns slice [p*W +: W] of every AR field and bit p of
// arvalid/arready/rvalid/rready. The R payload is shared by all agents.
interface axi_read_arbiter_if #(
  parameter int N_PORTS    = 1,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic [N_PORTS*ID_WIDTH-1:0]   arid;
  logic [N_PORTS*ADDR_WIDTH-1:0] araddr;
  logic [N_PORTS*LEN_WIDTH-1:0]  arlen;
  logic [N_PORTS*3-1:0]          arsize;
  logic [N_PORTS*2-1:0]          arburst;
  logic [N_PORTS-1:0]            arvalid;
  logic [N_PORTS-1:0]            arready;
  logic [ID_WIDTH-1:0]           rid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic [N_PORTS-1:0]            rvalid;
  logic [N_PORTS-1:0]            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: M0 (instruction fetch) and M1 (data) share one
// read slave, one burst in flight at a time. The granted master index is
// appended above the master ID to form the slave-side ID; R beats are routed
// by the registered grant only.
//
// Build option: define ARB_FIXED_PRIORITY_EN to make M0 win every tie
// (default build is round-robin between the two masters).
//
// state | meaning
// IDLE  | no burst in flight; grant a requester combinationally
// ADDR  | presenting the captured AR to the slave until accepted
// DATA  | forwarding R beats to the granted master until the rlast handshake
module axi_read_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int IDS_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_read_arbiter_if.slave  m,
  axi_read_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state;
  logic                  grant;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  arvalid_q;
  logic                  req;
  logic                  g;
`ifndef ARB_FIXED_PRIORITY_EN
  logic                  last_grant;
`endif

  // Requester selection for the IDLE cycle
  always_comb begin
    req = m.arvalid[0] | m.arvalid[1];
`ifdef ARB_FIXED_PRIORITY_EN
    g = ~m.arvalid[0];
`else
    g = (m.arvalid == 2'b11) ? ~last_grant : m.arvalid[1];
`endif
  end

  // Burst sequencing: capture AR on grant, hold it for the slave, track R
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      arvalid_q <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      // Pretend M1 went last so M0 wins the first tie after reset.
      last_grant <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            grant     <= g;
            id_q      <= g ? m.arid[2*ID_WIDTH-1:ID_WIDTH]       : m.arid[ID_WIDTH-1:0];
            addr_q    <= g ? m.araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m.araddr[ADDR_WIDTH-1:0];
            len_q     <= g ? m.arlen[2*LEN_WIDTH-1:LEN_WIDTH]    : m.arlen[LEN_WIDTH-1:0];
            size_q    <= g ? m.arsize[5:3]  : m.arsize[2:0];
            burst_q   <= g ? m.arburst[3:2] : m.arburst[1:0];
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (s.arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (s.rvalid && s.rready && s.rlast) begin
            state <= IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant <= grant;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master AR ready is only offered in IDLE and is forced low while in reset,
  // since the state register alone would still read IDLE then.
  assign m.arready = (state == IDLE && !rst && req) ? (g ? 2'b10 : 2'b01) : 2'b00;

  // R steering is by grant alone; the slave's upper rid bits are ignored.
  assign m.rvalid  = (state == DATA && s.rvalid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign s.rready  = (state == DATA) && (grant ? m.rready[1] : m.rready[0]);
  assign m.rid     = s.rid[ID_WIDTH-1:0];
  assign m.rdata   = s.rdata;
  assign m.rresp   = s.rresp;
  assign m.rlast   = s.rlast;

  logic unused_rid_hi;
  assign unused_rid_hi = ^s.rid[IDS_WIDTH-1:ID_WIDTH];

  assign s.arvalid = arvalid_q;
  assign s.arid    = IDS_WIDTH'({grant, id_q});
  assign s.araddr  = addr_q;
  assign s.arlen   = len_q;
  assign s.arsize  = size_q;
  assign s.arburst = burst_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: expected AR and R transactions are queued when
// stimulus is applied and popped when the arbiter shows them.
module tb_axi_read_arbiter;
  localparam int IW   = 4;
  localparam int IDSW = 8;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.N_PORTS(2), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) m_if ();
  axi_read_arbiter_if #(.N_PORTS(1), .ID_WIDTH(IDSW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) s_if ();

  axi_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .IDS_WIDTH(IDSW), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .rst(rst),
    .m  (m_if),
    .s  (s_if)
  );

  typedef struct {
    logic [IDSW-1:0] id;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   len;
  } ar_t;

  typedef struct {
    logic [1:0]    vld;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_t;

  ar_t  exp_ar[$];
  r_t   exp_r[$];
  int   n_cmp;
  int   n_bad;
  logic model_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_if.arid    = '0;
    m_if.araddr  = '0;
    m_if.arlen   = '0;
    m_if.arsize  = '0;
    m_if.arburst = '0;
    m_if.arvalid = 2'b00;
    m_if.rready  = 2'b11;
    s_if.arready = 1'b1;
    s_if.rid     = '0;
    s_if.rdata   = '0;
    s_if.rresp   = 2'b00;
    s_if.rlast   = 1'b0;
    s_if.rvalid  = 1'b0;
  endtask

  task automatic set_ar(input int mst, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    m_if.arid[mst*IW +: IW]    = id;
    m_if.araddr[mst*AW +: AW]  = addr;
    m_if.arlen[mst*LW +: LW]   = len;
    m_if.arsize[mst*3 +: 3]    = 3'd2;
    m_if.arburst[mst*2 +: 2]   = 2'd1;
  endtask

  task automatic drive_beat(input logic [IDSW-1:0] rid, input logic [DW-1:0] data, input logic [1:0] resp, input logic last);
    s_if.rvalid = 1'b1;
    s_if.rid    = rid;
    s_if.rdata  = data;
    s_if.rresp  = resp;
    s_if.rlast  = last;
  endtask

  function automatic logic exp_grant(input logic [1:0] v);
`ifdef ARB_FIXED_PRIORITY_EN
    return ~v[0];
`else
    return (v == 2'b11) ? ~model_last : v[1];
`endif
  endfunction

  function automatic logic [1:0] onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic ar_t mk_ar(input logic g, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    ar_t e;
    e.id   = {{(IDSW-IW-1){1'b0}}, g, id};
    e.addr = addr;
    e.len  = len;
    return e;
  endfunction

  function automatic r_t mk_r(input logic g, input logic [IW-1:0] id, input logic [DW-1:0] data, input logic [1:0] resp, input logic last);
    r_t r;
    r.vld  = onehot(g);
    r.id   = id;
    r.data = data;
    r.resp = resp;
    r.last = last;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_ar(0, 4'h1, 32'h0000_0100, 4'd0);
    set_ar(1, 4'h2, 32'h0000_0200, 4'd0);
    m_if.arvalid = 2'b11;
    repeat (2) step();
    samp();
    n_cmp++; if (m_if.arready !== 2'b00) begin n_bad++; $display("FAIL reset_arready: got %b want 00", m_if.arready); end
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_s_arvalid: got %b want 0", s_if.arvalid); end
    n_cmp++; if (m_if.rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", m_if.rvalid); end
    n_cmp++; if (s_if.rready !== 1'b0) begin n_bad++; $display("FAIL reset_s_rready: got %b want 0", s_if.rready); end
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b11))) begin n_bad++; $display("FAIL reset_first_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b11))); end
    m_if.arvalid = 2'b00;
    step();
    samp();
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_withdrawn: got s_arvalid %b want 0", s_if.arvalid); end
  endtask

  task automatic test_tie();
    ar_t  e;
    r_t   r;
    logic g;
    step();
    set_ar(0, 4'h5, 32'h0000_2000, 4'd0);
    set_ar(1, 4'h5, 32'h0000_3000, 4'd0);
    m_if.arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      samp();
      g = exp_grant(2'b11);
      n_cmp++; if (m_if.arready !== onehot(g)) begin n_bad++; $display("FAIL tie_grant[%0d]: got %b want %b", k, m_if.arready, onehot(g)); end
      exp_ar.push_back(mk_ar(g, 4'h5, g ? 32'h0000_3000 : 32'h0000_2000, 4'd0));
      step();
      samp();
      n_cmp++; if (s_if.arvalid !== 1'b1) begin n_bad++; $display("FAIL tie_arvalid[%0d]: got %b want 1", k, s_if.arvalid); end
      n_cmp++; if (m_if.arready !== 2'b00) begin n_bad++; $display("FAIL tie_addr_noready[%0d]: got %b want 00", k, m_if.arready); end
      if (exp_ar.size() == 0) begin n_cmp++; n_bad++; $display("FAIL tie_ar_queue: got empty want entry"); end
      else begin
        e = exp_ar.pop_front();
        n_cmp++; if ({s_if.arid, s_if.araddr, s_if.arlen} !== {e.id, e.addr, e.len}) begin n_bad++; $display("FAIL tie_ar[%0d]: got id %h addr %h len %h want id %h addr %h len %h", k, s_if.arid, s_if.araddr, s_if.arlen, e.id, e.addr, e.len); end
      end
      step();
      drive_beat({3'b000, g, 4'h5}, 32'hC0DE_0000 + k, 2'b00, 1'b1);
      exp_r.push_back(mk_r(g, 4'h5, 32'hC0DE_0000 + k, 2'b00, 1'b1));
      samp();
      r = exp_r.pop_front();
      n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, s_if.rready} !== {r.vld, r.id, r.data, r.resp, r.last, 1'b1}) begin n_bad++; $display("FAIL tie_r[%0d]: got vld %b id %h data %h rready %b want vld %b id %h data %h rready 1", k, m_if.rvalid, m_if.rid, m_if.rdata, s_if.rready, r.vld, r.id, r.data); end
      model_last = g;
      step();
      s_if.rvalid = 1'b0;
      if (k == 3) m_if.arvalid = 2'b00;
    end
  endtask

  task automatic test_single();
    ar_t e;
    r_t  r;
    step();
    set_ar(0, 4'h3, 32'h0000_1000, 4'd0);
    m_if.arvalid = 2'b01;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b01))) begin n_bad++; $display("FAIL single_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b01))); end
    exp_ar.push_back(mk_ar(1'b0, 4'h3, 32'h0000_1000, 4'd0));
    step();
    m_if.arvalid = 2'b00;
    samp();
    n_cmp++; if (s_if.arvalid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got s_arvalid %b want 1", s_if.arvalid); end
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arid, s_if.araddr, s_if.arlen} !== {e.id, e.addr, e.len}) begin n_bad++; $display("FAIL single_ar: got id %h addr %h want id %h addr %h", s_if.arid, s_if.araddr, e.id, e.addr); end
    step();
    drive_beat(8'h03, 32'hDEAD_BEEF, 2'b11, 1'b1);
    exp_r.push_back(mk_r(1'b0, 4'h3, 32'hDEAD_BEEF, 2'b11, 1'b1));
    samp();
    r = exp_r.pop_front();
    n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, s_if.rready} !== {r.vld, r.id, r.data, r.resp, r.last, 1'b1}) begin n_bad++; $display("FAIL single_r: got vld %b id %h data %h resp %b want vld %b id %h data %h resp %b", m_if.rvalid, m_if.rid, m_if.rdata, m_if.rresp, r.vld, r.id, r.data, r.resp); end
    model_last = 1'b0;
    step();
    s_if.rvalid = 1'b0;
    samp();
    n_cmp++; if ({m_if.rvalid, s_if.arvalid, m_if.arready} !== 5'b00000) begin n_bad++; $display("FAIL single_idle: got rvalid %b s_arvalid %b arready %b want all 0", m_if.rvalid, s_if.arvalid, m_if.arready); end
  endtask

  task automatic test_backpressure();
    ar_t  e;
    r_t   r;
    logic rr;
    int   beats;
    int   xfers;
    int   pushed;
    int   cyc;
    step();
    set_ar(1, 4'hA, 32'h0000_4000, 4'd3);
    m_if.arvalid = 2'b10;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b10))) begin n_bad++; $display("FAIL bp_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b10))); end
    exp_ar.push_back(mk_ar(1'b1, 4'hA, 32'h0000_4000, 4'd3));
    step();
    m_if.arvalid = 2'b00;
    samp();
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen} !== {1'b1, e.id, e.addr, e.len}) begin n_bad++; $display("FAIL bp_ar: got v %b id %h addr %h len %h want v 1 id %h addr %h len %h", s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen, e.id, e.addr, e.len); end
    beats = 0; xfers = 0; pushed = -1; cyc = 0;
    while (beats < 4 && cyc < 16) begin
      step();
      rr = (cyc % 2 == 0);
      m_if.rready = {rr, 1'b1};
      // Upper rid bits deliberately disagree with the grant.
      drive_beat(8'hEA, 32'h0000_B000 + beats, 2'b00, beats == 3);
      if (pushed != beats) begin
        exp_r.push_back(mk_r(1'b1, 4'hA, 32'h0000_B000 + beats, 2'b00, beats == 3));
        pushed = beats;
      end
      samp();
      n_cmp++; if (s_if.rready !== rr) begin n_bad++; $display("FAIL bp_rready_mirror[%0d]: got %b want %b", cyc, s_if.rready, rr); end
      n_cmp++; if (m_if.rvalid !== 2'b10) begin n_bad++; $display("FAIL bp_rvalid[%0d]: got %b want 10", cyc, m_if.rvalid); end
      if (s_if.rready === 1'b1 && s_if.rvalid === 1'b1) xfers++;
      if (rr) begin
        r = exp_r.pop_front();
        n_cmp++; if ({m_if.rid, m_if.rdata, m_if.rlast} !== {r.id, r.data, r.last}) begin n_bad++; $display("FAIL bp_beat[%0d]: got id %h data %h last %b want id %h data %h last %b", beats, m_if.rid, m_if.rdata, m_if.rlast, r.id, r.data, r.last); end
        beats++;
      end
      cyc++;
    end
    n_cmp++; if (xfers != 4) begin n_bad++; $display("FAIL bp_beat_count: got %0d want 4", xfers); end
    model_last = 1'b1;
    step();
    m_if.rready = 2'b11;
    drive_beat(8'h1A, 32'hBAD0_0000, 2'b00, 1'b1);
    samp();
    n_cmp++; if ({m_if.rvalid, s_if.rready} !== 3'b000) begin n_bad++; $display("FAIL bp_exit_idle: got rvalid %b s_rready %b want 00 0", m_if.rvalid, s_if.rready); end
    step();
    s_if.rvalid = 1'b0;
  endtask

  task automatic test_ar_stall();
    ar_t e;
    r_t  r;
    step();
    set_ar(0, 4'h7, 32'h0000_5000, 4'd0);
    set_ar(1, 4'h9, 32'h0000_6000, 4'd0);
    m_if.arvalid = 2'b01;
    s_if.arready = 1'b0;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b01))) begin n_bad++; $display("FAIL stall_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b01))); end
    exp_ar.push_back(mk_ar(1'b0, 4'h7, 32'h0000_5000, 4'd0));
    step();
    m_if.arvalid = 2'b10;
    drive_beat(8'h07, 32'h5555_0000, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      samp();
      n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr} !== {1'b1, 8'h07, 32'h0000_5000}) begin n_bad++; $display("FAIL stall_hold[%0d]: got v %b id %h addr %h want v 1 id 07 addr 00005000", i, s_if.arvalid, s_if.arid, s_if.araddr); end
      n_cmp++; if (m_if.arready !== 2'b00) begin n_bad++; $display("FAIL stall_pending[%0d]: got %b want 00", i, m_if.arready); end
      n_cmp++; if ({m_if.rvalid, s_if.rready} !== 3'b000) begin n_bad++; $display("FAIL stall_r_holdoff[%0d]: got rvalid %b s_rready %b want 00 0", i, m_if.rvalid, s_if.rready); end
      step();
    end
    s_if.arready = 1'b1;
    s_if.rvalid  = 1'b0;
    samp();
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen} !== {1'b1, e.id, e.addr, e.len}) begin n_bad++; $display("FAIL stall_ar: got v %b id %h addr %h want v 1 id %h addr %h", s_if.arvalid, s_if.arid, s_if.araddr, e.id, e.addr); end
    step();
    drive_beat(8'h07, 32'h7777_0001, 2'b10, 1'b1);
    exp_r.push_back(mk_r(1'b0, 4'h7, 32'h7777_0001, 2'b10, 1'b1));
    samp();
    r = exp_r.pop_front();
    n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, s_if.rready} !== {r.vld, r.id, r.data, r.resp, r.last, 1'b1}) begin n_bad++; $display("FAIL stall_r0: got vld %b id %h data %h want vld %b id %h data %h", m_if.rvalid, m_if.rid, m_if.rdata, r.vld, r.id, r.data); end
    model_last = 1'b0;
    step();
    s_if.rvalid = 1'b0;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b10))) begin n_bad++; $display("FAIL stall_next_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b10))); end
    exp_ar.push_back(mk_ar(1'b1, 4'h9, 32'h0000_6000, 4'd0));
    step();
    m_if.arvalid = 2'b00;
    samp();
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr} !== {1'b1, e.id, e.addr}) begin n_bad++; $display("FAIL stall_ar1: got v %b id %h addr %h want v 1 id %h addr %h", s_if.arvalid, s_if.arid, s_if.araddr, e.id, e.addr); end
    step();
    drive_beat(8'h19, 32'h9999_0002, 2'b01, 1'b1);
    exp_r.push_back(mk_r(1'b1, 4'h9, 32'h9999_0002, 2'b01, 1'b1));
    samp();
    r = exp_r.pop_front();
    n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, s_if.rready} !== {r.vld, r.id, r.data, r.resp, r.last, 1'b1}) begin n_bad++; $display("FAIL stall_r1: got vld %b id %h data %h want vld %b id %h data %h", m_if.rvalid, m_if.rid, m_if.rdata, r.vld, r.id, r.data); end
    model_last = 1'b1;
    step();
    s_if.rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    ar_t e;
    r_t  r;
    step();
    set_ar(1, 4'hC, 32'h0000_8000, 4'd3);
    set_ar(0, 4'h4, 32'h0000_9000, 4'd0);
    m_if.arvalid = 2'b10;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b10))) begin n_bad++; $display("FAIL mid_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b10))); end
    exp_ar.push_back(mk_ar(1'b1, 4'hC, 32'h0000_8000, 4'd3));
    step();
    m_if.arvalid = 2'b00;
    samp();
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen} !== {1'b1, e.id, e.addr, e.len}) begin n_bad++; $display("FAIL mid_ar: got v %b id %h addr %h len %h want v 1 id %h addr %h len %h", s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen, e.id, e.addr, e.len); end
    for (int b = 0; b < 2; b++) begin
      step();
      drive_beat(8'h1C, 32'h0000_A000 + b, 2'b00, 1'b0);
      exp_r.push_back(mk_r(1'b1, 4'hC, 32'h0000_A000 + b, 2'b00, 1'b0));
      samp();
      r = exp_r.pop_front();
      n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rlast} !== {r.vld, r.id, r.data, r.last}) begin n_bad++; $display("FAIL mid_beat[%0d]: got vld %b id %h data %h want vld %b id %h data %h", b, m_if.rvalid, m_if.rid, m_if.rdata, r.vld, r.id, r.data); end
    end
    step();
    drive_beat(8'h1C, 32'h0000_A002, 2'b00, 1'b0);
    samp();
    n_cmp++; if (m_if.rvalid !== 2'b10) begin n_bad++; $display("FAIL mid_beat2_live: got %b want 10", m_if.rvalid); end
    #2;
    m_if.arvalid = 2'b11;
    rst = 1'b1;
    #1;
    n_cmp++; if ({m_if.arready, m_if.rvalid, s_if.rready, s_if.arvalid} !== 6'b000000) begin n_bad++; $display("FAIL mid_reset_outputs: got arready %b rvalid %b s_rready %b s_arvalid %b want all 0", m_if.arready, m_if.rvalid, s_if.rready, s_if.arvalid); end
    s_if.rvalid = 1'b0;
    model_last = 1'b1;
    exp_r.delete();
    exp_ar.delete();
    repeat (2) step();
    rst = 1'b0;
    samp();
    n_cmp++; if (m_if.arready !== onehot(exp_grant(2'b11))) begin n_bad++; $display("FAIL mid_post_reset_grant: got %b want %b", m_if.arready, onehot(exp_grant(2'b11))); end
    exp_ar.push_back(mk_ar(1'b0, 4'h4, 32'h0000_9000, 4'd0));
    step();
    m_if.arvalid = 2'b00;
    samp();
    e = exp_ar.pop_front();
    n_cmp++; if ({s_if.arvalid, s_if.arid, s_if.araddr} !== {1'b1, e.id, e.addr}) begin n_bad++; $display("FAIL mid_post_ar: got v %b id %h addr %h want v 1 id %h addr %h", s_if.arvalid, s_if.arid, s_if.araddr, e.id, e.addr); end
    step();
    drive_beat(8'h04, 32'h4444_0004, 2'b00, 1'b1);
    exp_r.push_back(mk_r(1'b0, 4'h4, 32'h4444_0004, 2'b00, 1'b1));
    samp();
    r = exp_r.pop_front();
    n_cmp++; if ({m_if.rvalid, m_if.rid, m_if.rdata, m_if.rlast, s_if.rready} !== {r.vld, r.id, r.data, r.last, 1'b1}) begin n_bad++; $display("FAIL mid_post_r: got vld %b id %h data %h want vld %b id %h data %h", m_if.rvalid, m_if.rid, m_if.rdata, r.vld, r.id, r.data); end
    model_last = 1'b0;
    step();
    s_if.rvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_last = 1'b1;
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_ar_stall();
    test_reset_mid();
    repeat (2) step();
    n_cmp++; if (exp_ar.size() != 0 || exp_r.size() != 0) begin n_bad++; $display("FAIL sb_drain: got ar %0d r %0d left want 0 0", exp_ar.size(), exp_r.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
